// File: rtl/morse_symbol_capture.sv
// Morse key front end: synchronise and debounce the raw key, time each press as
// dot or dash, and pack up to five symbols into a character closed by a release gap.
module morse_symbol_capture #(
  parameter int DEB_CYC  = 1_000_000,
  parameter int DASH_CYC = 30_000_000,
  parameter int GAP_CYC  = 60_000_000,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw,
  output logic       key_db,
  output logic       sym_valid,
  output logic       sym_dash,
  output logic       char_valid,
  output logic [4:0] char_code,
  output logic [2:0] char_len,
  output logic       char_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] DASH_LIM = CNT_W'(DASH_CYC);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  logic             sync1_q, sync2_q;
  logic             key_db_q, key_db_d;
  logic             db_prev_q;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [4:0]       buf_q, buf_d;

  logic             sym_valid_q, sym_valid_d;
  logic             sym_dash_q, sym_dash_d;
  logic             char_valid_q, char_valid_d;
  logic [4:0]       char_code_q, char_code_d;
  logic [2:0]       char_len_q, char_len_d;
  logic             char_err_q, char_err_d;

  logic             rise_s, fall_s;
  logic [CNT_W-1:0] dur_inc_s;
  logic             press_dash_s;

  // Two-flop synchroniser for the asynchronous key input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer: toggle only after DEB_CYC consecutive cycles of disagreement.
  always_comb begin
    key_db_d  = key_db_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q != key_db_q) begin
      if (deb_cnt_q >= DEB_LAST) begin
        key_db_d  = ~key_db_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_ONE;
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // Debouncer and edge-detect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_db_q  <= 1'b0;
      deb_cnt_q <= '0;
      db_prev_q <= 1'b0;
    end else begin
      key_db_q  <= key_db_d;
      deb_cnt_q <= deb_cnt_d;
      db_prev_q <= key_db_q;
    end
  end

  assign rise_s = key_db_q & ~db_prev_q;
  assign fall_s = ~key_db_q & db_prev_q;

  // The fall cycle itself counts, so the classified length equals the high time.
  assign dur_inc_s    = sat_inc(dur_q);
  assign press_dash_s = (dur_inc_s >= DASH_LIM);

  // Symbol/character FSM: next state, counters and output strobes.
  always_comb begin
    state_d      = state_q;
    dur_d        = dur_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    sym_valid_d  = 1'b0;
    sym_dash_d   = 1'b0;
    char_valid_d = 1'b0;
    char_err_d   = 1'b0;
    char_code_d  = char_code_q;
    char_len_d   = char_len_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d = ST_PRESS;
          dur_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (fall_s) begin
          sym_valid_d = 1'b1;
          sym_dash_d  = press_dash_s;
          dur_d       = '0;
          if (cnt_q == 3'd5) begin
            char_err_d = 1'b1;
            buf_d      = 5'd0;
            cnt_d      = 3'd0;
            state_d    = ST_IDLE;
          end else begin
            buf_d   = buf_q | (5'(press_dash_s) << cnt_q);
            cnt_d   = cnt_q + 3'd1;
            state_d = ST_GAP;
          end
        end else begin
          dur_d = dur_inc_s;
        end
      end
      ST_GAP: begin
        if (dur_q >= GAP_LIM) begin
          char_valid_d = 1'b1;
          char_code_d  = buf_q;
          char_len_d   = cnt_q;
          buf_d        = 5'd0;
          cnt_d        = 3'd0;
          dur_d        = '0;
          // A press landing on the timeout cycle still starts a new character.
          if (rise_s) begin
            state_d = ST_PRESS;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (rise_s) begin
          state_d = ST_PRESS;
          dur_d   = '0;
        end else begin
          dur_d = dur_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dur_d   = '0;
        cnt_d   = 3'd0;
        buf_d   = 5'd0;
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dur_q        <= '0;
      cnt_q        <= 3'd0;
      buf_q        <= 5'd0;
      sym_valid_q  <= 1'b0;
      sym_dash_q   <= 1'b0;
      char_valid_q <= 1'b0;
      char_code_q  <= 5'd0;
      char_len_q   <= 3'd0;
      char_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dur_q        <= dur_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      sym_valid_q  <= sym_valid_d;
      sym_dash_q   <= sym_dash_d;
      char_valid_q <= char_valid_d;
      char_code_q  <= char_code_d;
      char_len_q   <= char_len_d;
      char_err_q   <= char_err_d;
    end
  end

  assign key_db     = key_db_q;
  assign sym_valid  = sym_valid_q;
  assign sym_dash   = sym_dash_q;
  assign char_valid = char_valid_q;
  assign char_code  = char_code_q;
  assign char_len   = char_len_q;
  assign char_err   = char_err_q;

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Directed bench for morse_symbol_capture: expected pulses are queued as keys
// are driven and compared by a monitor when the DUT emits them.
module tb_morse_symbol_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_raw;
  logic       key_db;
  logic       sym_valid;
  logic       sym_dash;
  logic       char_valid;
  logic [4:0] char_code;
  logic [2:0] char_len;
  logic       char_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_char;
    logic       dash;
    logic       err;
    logic [4:0] code;
    logic [2:0] len;
  } ev_t;

  ev_t sb[$];

  morse_symbol_capture #(
    .DEB_CYC (4),
    .DASH_CYC(20),
    .GAP_CYC (40),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .key_db    (key_db),
    .sym_valid (sym_valid),
    .sym_dash  (sym_dash),
    .char_valid(char_valid),
    .char_code (char_code),
    .char_len  (char_len),
    .char_err  (char_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  function automatic void push_sym(input logic dash, input logic err);
    ev_t e;
    e = '{is_char: 1'b0, dash: dash, err: err, code: 5'd0, len: 3'd0};
    sb.push_back(e);
  endfunction

  function automatic void push_char(input logic [4:0] code, input logic [2:0] len);
    ev_t e;
    e = '{is_char: 1'b1, dash: 1'b0, err: 1'b0, code: code, len: len};
    sb.push_back(e);
  endfunction

  // Scoreboard monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    ev_t exp_e;
    if (!rst && (sym_valid || char_valid || char_err)) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: observed sv=%0b cv=%0b ce=%0b, expected no pulse",
               sym_valid, char_valid, char_err);
      end
      if (sb.size() > 0) begin
        exp_e = sb.pop_front();
        checks++;
        assert ({sym_valid, char_valid} === {~exp_e.is_char, exp_e.is_char}) else begin
          errors++;
          $error("FAIL pulse_kind: observed sv/cv=%b%b, expected %b%b",
                 sym_valid, char_valid, ~exp_e.is_char, exp_e.is_char);
        end
        if (exp_e.is_char) begin
          checks++;
          assert ({char_code, char_len, char_err} === {exp_e.code, exp_e.len, 1'b0}) else begin
            errors++;
            $error("FAIL char: observed code=%b len=%0d err=%0b, expected code=%b len=%0d err=0",
                   char_code, char_len, char_err, exp_e.code, exp_e.len);
          end
        end else begin
          checks++;
          assert ({sym_dash, char_err} === {exp_e.dash, exp_e.err}) else begin
            errors++;
            $error("FAIL sym: observed dash=%0b err=%0b, expected dash=%0b err=%0b",
                   sym_dash, char_err, exp_e.dash, exp_e.err);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    key_raw = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    key_raw = 1'b1;
    repeat (n) @(negedge clk);
    key_raw = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s_drain: observed %0d pending events, expected 0", tag, sb.size());
    end
    sb.delete();
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    key_raw = 1'b0;
    @(negedge clk);

    // Reset held while the key toggles.
    for (int i = 0; i < 12; i++) begin
      key_raw = ~key_raw;
      repeat (2) @(negedge clk);
      checks++;
      assert ({key_db, sym_valid, sym_dash, char_valid, char_code, char_len, char_err} === 13'd0)
      else begin
        errors++;
        $error("FAIL reset_outputs: observed %b, expected 0",
               {key_db, sym_valid, sym_dash, char_valid, char_code, char_len, char_err});
      end
    end
    key_raw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(200);

    // Single dot: "E".
    push_sym(1'b0, 1'b0);
    push_char(5'b00000, 3'd1);
    press(10);
    idle(50);
    drain("E");

    // Dash dot dash dot: "C", code must hold after the pulse.
    push_sym(1'b1, 1'b0);
    push_sym(1'b0, 1'b0);
    push_sym(1'b1, 1'b0);
    push_sym(1'b0, 1'b0);
    push_char(5'b00101, 3'd4);
    press(25); idle(8);
    press(10); idle(8);
    press(25); idle(8);
    press(10); idle(60);
    drain("C");
    checks++;
    assert ({char_code, char_len} === {5'b00101, 3'd4}) else begin
      errors++;
      $error("FAIL C_hold: observed code=%b len=%0d, expected code=00101 len=4", char_code, char_len);
    end

    // Dot/dash threshold.
    push_sym(1'b0, 1'b0);
    push_char(5'b00000, 3'd1);
    press(19);
    idle(60);
    drain("len19");
    push_sym(1'b1, 1'b0);
    push_char(5'b00001, 3'd1);
    press(20);
    idle(60);
    drain("len20");

    // Sixth symbol overflows: error pulse, character discarded.
    for (int i = 0; i < 5; i++) push_sym(1'b0, 1'b0);
    push_sym(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      press(10);
      idle(8);
    end
    idle(60);
    drain("overflow");
    checks++;
    assert ({char_code, char_len} === {5'b00001, 3'd1}) else begin
      errors++;
      $error("FAIL overflow_no_char: observed code=%b len=%0d, expected code=00001 len=1",
             char_code, char_len);
    end
    push_sym(1'b0, 1'b0);
    push_char(5'b00000, 3'd1);
    press(10);
    idle(60);
    drain("after_err");

    // Glitches during the gap must not reach key_db.
    push_sym(1'b0, 1'b0);
    push_char(5'b00000, 3'd1);
    press(10);
    idle(10);
    for (int g = 1; g <= 3; g++) begin
      key_raw = 1'b1;
      repeat (g) @(negedge clk);
      key_raw = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checks++;
        assert (key_db === 1'b0) else begin
          errors++;
          $error("FAIL glitch_key_db: observed %b, expected 0 (glitch %0d)", key_db, g);
        end
      end
    end
    idle(60);
    drain("glitch");

    // Reset mid-press: no pulses, character state cleared.
    key_raw = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    key_raw = 1'b0;
    idle(80);
    drain("rst_mid");
    checks++;
    assert ({key_db, char_code, char_len} === 9'd0) else begin
      errors++;
      $error("FAIL rst_mid_state: observed key_db=%b code=%b len=%0d, expected all 0",
             key_db, char_code, char_len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_symbol_capture.md
# morse_symbol_capture

Front end for the Morse decoder path. It takes one raw push-button (the Morse key), then synchronises and debounces it. It times each press and classifies it as dot or dash, and packs up to five symbols into a character. When the key stays released for a gap timeout, it emits the character as a 5-bit code plus a 3-bit length, which is the per-character format the decoder stores and the seven-segment display path renders.

## Interface
Parameters:
- DEB_CYC, 1_000_000 — consecutive stable clk cycles needed to accept a level change (10 ms at 100 MHz).
- DASH_CYC, 30_000_000 — debounced press length at or above which the symbol is a dash (300 ms).
- GAP_CYC, 60_000_000 — debounced release length that closes a character (600 ms).
- CNT_W, 27 — width of the duration and debounce counters. Must hold max(DEB_CYC, DASH_CYC, GAP_CYC).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset. Asynchronous and active-high; clears every register.
- key_raw  in  1  raw Morse key, 1 = pressed. Asynchronous to clk and bouncy.
- key_db  out  1  debounced key level, for the mode LED.
- sym_valid  out  1  one-cycle pulse when a symbol is classified.
- sym_dash  out  1  symbol type, valid with sym_valid: 1 = dash, 0 = dot.
- char_valid  out  1  one-cycle pulse when a character is closed.
- char_code  out  5  symbols of the last closed character. Bit 0 is the first symbol; 1 = dash. Unused high bits are 0. Held until the next char_valid.
- char_len  out  3  symbol count of the last closed character, 1..5. Held like char_code.
- char_err  out  1  one-cycle pulse when a 6th symbol is entered; that character is discarded.

## Operation
- Input conditioning: a 2-FF synchroniser feeds a debouncer. The debouncer counts cycles in which the synced level differs from key_db; any cycle where they are equal clears the count. When the count reaches DEB_CYC, key_db toggles and the count clears.
- FSM states:
  - IDLE: released, buffer empty.
  - PRESS: key down, dur counting.
  - GAP: released, buffer non-empty, dur counting.
- IDLE → PRESS on the key_db rising edge; dur is cleared.
- PRESS → GAP on the key_db falling edge:
  - classify: dash = (dur ≥ DASH_CYC);
  - pulse sym_valid/sym_dash;
  - write the symbol into bit position cnt, then cnt += 1;
  - clear dur.
- PRESS with a 6th symbol (cnt = 5 at the falling edge):
  - pulse sym_valid and char_err together;
  - clear the buffer and cnt;
  - go to IDLE; no char_valid.
- GAP → PRESS on a key_db rising edge before the timeout; dur is cleared and the buffer is kept.
- GAP → IDLE when dur reaches GAP_CYC:
  - pulse char_valid;
  - load char_code/char_len from the buffer and cnt;
  - clear the buffer and cnt.
- dur saturates at all-ones and never wraps. A held key stays a dash.
- Unused buffer bits are always 0, so char_code bits at or above char_len read 0.

## Timing
- Reset values: key_db = 0, sym_valid = 0, sym_dash = 0, char_valid = 0, char_code = 0, char_len = 0, char_err = 0. State is IDLE; all counters are 0.
- key_raw edge to key_db change: 2 sync cycles + DEB_CYC cycles, assuming no bounce after the edge.
- Edge-to-output latency:
  - key_db falling edge → sym_valid one cycle later (registered);
  - dur reaching GAP_CYC → char_valid on the next cycle.
- Measured press length equals the debounced high time exactly: dur counts from the cycle after the rise up to the fall cycle.
- Boundary case: press = DASH_CYC − 1 gives a dot; press = DASH_CYC gives a dash.
- Pulses are exactly one cycle; there is no back-pressure. The consumer must sample on the pulse.
- rst asserted mid-press or mid-gap clears everything at once. The partial character is lost and no pulse is emitted. After release, a key still held is treated as a new press once debounced.
- char_valid and sym_valid never coincide. char_err coincides only with sym_valid.

## Test plan
Bench parameters: DEB_CYC = 4, DASH_CYC = 20, GAP_CYC = 40.
- Reset held while key_raw toggles → all outputs 0. After release with key idle, no pulses for 200 cycles.
- Press 10 cycles (debounced), release 50 → sym_valid with sym_dash = 0, then char_valid with char_code = 5'b00000, char_len = 1 ("E").
- Presses of 25, 10, 25, 10 with 8-cycle gaps, then idle → four sym_valid with dash = 1, 0, 1, 0; char_code = 5'b00101, char_len = 4 ("C"). Check that char_code holds after the pulse.
- Press of exactly 19 then a gap, and exactly 20 then a gap → dot, then dash.
- Six 10-cycle presses with 8-cycle gaps → five sym_valid, then a sixth sym_valid with char_err. No char_valid follows; the next single dot yields char_len = 1.
- key_raw glitches of 1–3 cycles during GAP → key_db unchanged and no symbol. A rst pulse mid-press of 15 cycles → no sym_valid, and char_len stays 0.
